stereo_dsp_sequencer: RTL and testbench
=======================================

Name: stereo_dsp_sequencer

Overview:
- Top-level sequencer for the stereo filter datapath.
- After reset it clears sample memory, then loads 16 rj words and 512 coefficient words from the serial input stream.
- It then runs the per-sample flow: write the sample to the circular buffer, start both L/R ALUs, and wait for both to finish.
- It enters sleep after a run of all-zero input samples and services flush requests by clearing sample memory.

Parameters:
- RJ_COUNT, 16, rj words loaded after init
- COEFF_COUNT, 512, coefficient words loaded after rj
- DATA_DEPTH, 256, circular sample buffer entries (power of 2)
- ZERO_LIMIT, 800, consecutive all-zero samples that trigger sleep

Ports:
- Sclk  in  1  system clock, all logic on posedge
- uni_reset  in  1  synchronous, active-high reset
- word_valid  in  1  one-cycle pulse: new 16-bit L/R input word ready (already synchronized to Sclk)
- all_zero  in  1  current input word is zero on both channels; valid with word_valid
- flush  in  1  level request to clear sample memory
- alu_finish_L  in  1  left ALU done, one-cycle pulse
- alu_finish_R  in  1  right ALU done, one-cycle pulse
- rj_we  out  1  rj memory write strobe
- rj_addr  out  4  rj write address
- coeff_we  out  1  coefficient write strobe
- coeff_addr  out  9  coefficient write address
- data_we  out  1  sample memory write strobe
- data_clear  out  1  with data_we: write zero instead of input word
- data_addr  out  8  sample write address
- alu_start  out  1  one-cycle start pulse to both ALUs
- sleep_flag  out  1  high while in SLEEP
- overrun  out  1  sticky: word arrived while ALUs busy
- state_dbg  out  3  encoded current state

Behaviour:
- All outputs are registered. Synchronous reset clears every output, counter and address to 0 and sets state INIT.
- States and encodings: INIT=0, LOAD_RJ=1, LOAD_COEFF=2, WORK=3, SLEEP=4, CLEAR=5.
- INIT:
  - data_we=data_clear=1 every cycle; data_addr sweeps 0..DATA_DEPTH-1.
  - After the last address (256 cycles), go to LOAD_RJ with data_addr=0.
  - word_valid is ignored in INIT.
- LOAD_RJ:
  - Each word_valid gives rj_we=1 for one cycle in the next cycle at the current rj_addr; rj_addr then increments.
  - On the RJ_COUNT-th write, go to LOAD_COEFF.
- LOAD_COEFF: same scheme with coeff_we/coeff_addr. On the COEFF_COUNT-th write, go to WORK.
- flush is ignored in INIT, LOAD_RJ and LOAD_COEFF.
- WORK, per word_valid:
  - Cycle+1: data_we=1, data_clear=0 at data_addr; data_addr then increments mod DATA_DEPTH (255 wraps to 0).
  - Cycle+2: alu_start=1, alu_busy set.
  - alu_busy clears once both alu_finish_L and alu_finish_R have been seen. They may arrive in either order or in the same cycle.
  - If word_valid arrives while alu_busy=1: the sample is still written, alu_start is suppressed for that word, and overrun is set (sticky until reset).
- Zero counter (WORK only):
  - Increments on word_valid with all_zero=1; clears on word_valid with all_zero=0.
  - The word that brings the count to ZERO_LIMIT is written and started normally. The state then moves to SLEEP after its alu_start.
- SLEEP:
  - sleep_flag=1. Words with all_zero=1 are dropped: no write, no start.
  - A word with all_zero=0 exits to WORK: the zero counter clears and the word follows the normal WORK timing (write at +1, start at +2). sleep_flag falls in the same cycle as that data_we.
- flush in WORK or SLEEP:
  - Go to CLEAR. If alu_busy, wait for it to clear first.
  - CLEAR sweeps data_addr 0..DATA_DEPTH-1 with data_we=data_clear=1, then resets data_addr and the zero counter to 0 and returns to WORK.
  - rj and coeff contents are retained.
  - If flush is still high on exit, CLEAR repeats.
- Simultaneous events:
  - flush together with word_valid: flush wins and the word is dropped.
  - word_valid during CLEAR: the word is dropped.
- uni_reset in any state, including mid-load or mid-clear, restarts from INIT. All load progress is lost.

Test Plan:
- Reset, then 256 cycles -> data_we=data_clear=1 with data_addr 0..255, then state_dbg=1, all strobes 0.
- 16 word_valid pulses then 512 more -> rj_we at rj_addr 0..15, coeff_we at coeff_addr 0..511, state_dbg=3 after the 528th word.
- In WORK, 300 non-zero words with finishes returned 20 cycles after each start -> data_addr 0..255 then wraps to 0..43; every alu_start lands 2 cycles after word_valid; overrun=0.
- 800 all-zero words -> the 800th is written and started, then sleep_flag=1; 5 more zero words produce no strobes; a non-zero word clears sleep_flag, data_we follows at +1 and alu_start at +2.
- Word arrives while alu_finish_R is still pending -> data_we=1, no alu_start, overrun=1 and held.
- flush pulse in WORK while ALU busy -> CLEAR starts only after both finishes, runs 256 cleared writes, data_addr=0, rj/coeff untouched (no rj_we/coeff_we); uni_reset mid-LOAD_COEFF returns to INIT with coeff_addr=0.

Source files
------------

// File: rtl/stereo_dsp_sequencer.sv
// Stereo filter sequencer: clears sample memory, loads rj/coeff words,
// then paces per-sample writes and L/R ALU starts, with sleep and flush.
module stereo_dsp_sequencer #(
  parameter int RJ_COUNT    = 16,
  parameter int COEFF_COUNT = 512,
  parameter int DATA_DEPTH  = 256,
  parameter int ZERO_LIMIT  = 800
) (
  input  logic                           Sclk,
  input  logic                           uni_reset,
  input  logic                           word_valid,
  input  logic                           all_zero,
  input  logic                           flush,
  input  logic                           alu_finish_L,
  input  logic                           alu_finish_R,
  output logic                           rj_we,
  output logic [$clog2(RJ_COUNT)-1:0]    rj_addr,
  output logic                           coeff_we,
  output logic [$clog2(COEFF_COUNT)-1:0] coeff_addr,
  output logic                           data_we,
  output logic                           data_clear,
  output logic [$clog2(DATA_DEPTH)-1:0]  data_addr,
  output logic                           alu_start,
  output logic                           sleep_flag,
  output logic                           overrun,
  output logic [2:0]                     state_dbg
);

  localparam int RAW = $clog2(RJ_COUNT);
  localparam int CAW = $clog2(COEFF_COUNT);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int ZW  = $clog2(ZERO_LIMIT + 1);

  localparam logic [RAW-1:0] RLAST = RAW'(RJ_COUNT - 1);
  localparam logic [CAW-1:0] CLAST = CAW'(COEFF_COUNT - 1);
  localparam logic [DAW-1:0] DLAST = DAW'(DATA_DEPTH - 1);
  localparam logic [ZW-1:0]  ZMAX  = ZW'(ZERO_LIMIT);

  typedef enum logic [2:0] {
    INIT       = 3'd0,
    LOAD_RJ    = 3'd1,
    LOAD_COEFF = 3'd2,
    WORK       = 3'd3,
    SLEEP      = 3'd4,
    CLEAR      = 3'd5
  } state_t;

  state_t         state, state_n;
  logic           data_we_n, data_clear_n;
  logic [DAW-1:0] data_addr_n;
  logic           rj_we_n, coeff_we_n;
  logic [RAW-1:0] rj_addr_n;
  logic [CAW-1:0] coeff_addr_n;
  logic           alu_start_n, sleep_flag_n, overrun_n;

  // start_pend: word written, start goes out next cycle
  logic           start_pend, start_pend_n;
  logic           alu_busy, alu_busy_n;
  logic           seen_l, seen_l_n;
  logic           seen_r, seen_r_n;
  logic [ZW-1:0]  zcnt, zcnt_n;
  // sarm: two-stage delay so SLEEP follows the limit word's start
  logic [1:0]     sarm, sarm_n;
  // flush_req: flush pulse held until the ALUs go idle
  logic           flush_req, flush_req_n;

  logic           busy_any;
  logic           done_l, done_r;
  logic           take, go_clear;

  assign busy_any  = alu_busy | start_pend;
  assign done_l    = seen_l | alu_finish_L;
  assign done_r    = seen_r | alu_finish_R;
  assign state_dbg = state;

  // State register and all registered outputs
  always_ff @(posedge Sclk) begin
    if (uni_reset) begin
      state      <= INIT;
      data_we    <= 1'b0;
      data_clear <= 1'b0;
      data_addr  <= '0;
      rj_we      <= 1'b0;
      rj_addr    <= '0;
      coeff_we   <= 1'b0;
      coeff_addr <= '0;
      alu_start  <= 1'b0;
      sleep_flag <= 1'b0;
      overrun    <= 1'b0;
      start_pend <= 1'b0;
      alu_busy   <= 1'b0;
      seen_l     <= 1'b0;
      seen_r     <= 1'b0;
      zcnt       <= '0;
      sarm       <= '0;
      flush_req  <= 1'b0;
    end else begin
      state      <= state_n;
      data_we    <= data_we_n;
      data_clear <= data_clear_n;
      data_addr  <= data_addr_n;
      rj_we      <= rj_we_n;
      rj_addr    <= rj_addr_n;
      coeff_we   <= coeff_we_n;
      coeff_addr <= coeff_addr_n;
      alu_start  <= alu_start_n;
      sleep_flag <= sleep_flag_n;
      overrun    <= overrun_n;
      start_pend <= start_pend_n;
      alu_busy   <= alu_busy_n;
      seen_l     <= seen_l_n;
      seen_r     <= seen_r_n;
      zcnt       <= zcnt_n;
      sarm       <= sarm_n;
      flush_req  <= flush_req_n;
    end
  end

  // Next-state, strobes and address stepping
  always_comb begin
    state_n      = state;
    data_we_n    = 1'b0;
    data_clear_n = 1'b0;
    // addresses advance the cycle after their write strobe
    data_addr_n  = data_addr + DAW'(data_we);
    rj_we_n      = 1'b0;
    rj_addr_n    = rj_addr + RAW'(rj_we);
    coeff_we_n   = 1'b0;
    coeff_addr_n = coeff_addr + CAW'(coeff_we);
    alu_start_n  = start_pend;
    start_pend_n = 1'b0;
    overrun_n    = overrun;
    zcnt_n       = zcnt;
    sarm_n       = {sarm[0], 1'b0};
    flush_req_n  = flush_req;
    alu_busy_n   = alu_busy;
    seen_l_n     = seen_l;
    seen_r_n     = seen_r;
    take         = 1'b0;
    go_clear     = 1'b0;

    if (alu_busy) begin
      if (done_l && done_r) begin
        alu_busy_n = 1'b0;
        seen_l_n   = 1'b0;
        seen_r_n   = 1'b0;
      end else begin
        seen_l_n = done_l;
        seen_r_n = done_r;
      end
    end
    if (start_pend) alu_busy_n = 1'b1;

    case (state)
      INIT: begin
        if (data_we && data_addr == DLAST) begin
          state_n = LOAD_RJ;
        end else begin
          data_we_n    = 1'b1;
          data_clear_n = 1'b1;
        end
      end
      LOAD_RJ: begin
        if (word_valid) begin
          rj_we_n = 1'b1;
          if (rj_addr_n == RLAST) state_n = LOAD_COEFF;
        end
      end
      LOAD_COEFF: begin
        if (word_valid) begin
          coeff_we_n = 1'b1;
          if (coeff_addr_n == CLAST) state_n = WORK;
        end
      end
      WORK: begin
        if (flush || flush_req) begin
          if (busy_any) flush_req_n = 1'b1;
          else go_clear = 1'b1;
        end else begin
          if (word_valid) begin
            take = 1'b1;
            if (all_zero) begin
              if (zcnt != ZMAX) begin
                zcnt_n = zcnt + 1'b1;
                if (zcnt == ZMAX - 1'b1) sarm_n[0] = 1'b1;
              end
            end else begin
              zcnt_n = '0;
            end
          end
          if (sarm[1]) state_n = SLEEP;
        end
      end
      SLEEP: begin
        if (flush || flush_req) begin
          if (busy_any) flush_req_n = 1'b1;
          else go_clear = 1'b1;
        end else if (word_valid && !all_zero) begin
          take    = 1'b1;
          zcnt_n  = '0;
          state_n = WORK;
        end
      end
      CLEAR: begin
        if (data_we && data_addr == DLAST) begin
          zcnt_n      = '0;
          flush_req_n = 1'b0;
          if (!flush) state_n = WORK;
        end else begin
          data_we_n    = 1'b1;
          data_clear_n = 1'b1;
        end
      end
      default: state_n = INIT;
    endcase

    if (take) begin
      data_we_n = 1'b1;
      if (busy_any) overrun_n = 1'b1;
      else start_pend_n = 1'b1;
    end

    if (go_clear) begin
      state_n     = CLEAR;
      data_addr_n = '0;
      flush_req_n = 1'b0;
      sarm_n      = '0;
      zcnt_n      = '0;
    end

    sleep_flag_n = (state_n == SLEEP);
  end

endmodule

// File: tb/tb_stereo_dsp_sequencer.sv
// Directed bench for stereo_dsp_sequencer: sweeps, loads, work flow,
// sleep entry/exit, overrun, flush-after-busy and mid-load reset.
module tb_stereo_dsp_sequencer;

  logic       Sclk = 1'b0;
  logic       uni_reset;
  logic       word_valid;
  logic       all_zero;
  logic       flush;
  logic       alu_finish_L;
  logic       alu_finish_R;
  logic       rj_we;
  logic [3:0] rj_addr;
  logic       coeff_we;
  logic [8:0] coeff_addr;
  logic       data_we;
  logic       data_clear;
  logic [7:0] data_addr;
  logic       alu_start;
  logic       sleep_flag;
  logic       overrun;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  stereo_dsp_sequencer dut (
    .Sclk        (Sclk),
    .uni_reset   (uni_reset),
    .word_valid  (word_valid),
    .all_zero    (all_zero),
    .flush       (flush),
    .alu_finish_L(alu_finish_L),
    .alu_finish_R(alu_finish_R),
    .rj_we       (rj_we),
    .rj_addr     (rj_addr),
    .coeff_we    (coeff_we),
    .coeff_addr  (coeff_addr),
    .data_we     (data_we),
    .data_clear  (data_clear),
    .data_addr   (data_addr),
    .alu_start   (alu_start),
    .sleep_flag  (sleep_flag),
    .overrun     (overrun),
    .state_dbg   (state_dbg)
  );

  always #5 Sclk = ~Sclk;

  typedef struct {
    logic       wv;
    logic       az;
    logic       fl;
    logic       fin_l;
    logic       fin_r;
    logic       we;
    logic       clr;
    logic [7:0] addr;
    logic       st;
    logic       slp;
    logic       ovr;
    logic [2:0] sd;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Sclk);
    #1;
  endtask

  task automatic word(input logic z);
    word_valid = 1'b1;
    all_zero   = z;
    step();
    word_valid = 1'b0;
    all_zero   = 1'b0;
  endtask

  task automatic finish_both();
    alu_finish_L = 1'b1;
    alu_finish_R = 1'b1;
    step();
    alu_finish_L = 1'b0;
    alu_finish_R = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,8'd76,1'b0,1'b0,1'b0,3'd3};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,8'd77,1'b1,1'b0,1'b0,3'd3};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,8'd77,1'b0,1'b0,1'b0,3'd3};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,8'd77,1'b0,1'b0,1'b0,3'd3};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,8'd77,1'b0,1'b0,1'b1,3'd3};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,8'd78,1'b0,1'b0,1'b1,3'd3};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,8'd78,1'b0,1'b0,1'b1,3'd3};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,8'd78,1'b0,1'b0,1'b1,3'd3};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,8'd79,1'b1,1'b0,1'b1,3'd3};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,8'd79,1'b0,1'b0,1'b1,3'd3};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,8'd79,1'b0,1'b0,1'b1,3'd3};

    uni_reset    = 1'b1;
    word_valid   = 1'b0;
    all_zero     = 1'b0;
    flush        = 1'b0;
    alu_finish_L = 1'b0;
    alu_finish_R = 1'b0;
    step();
    step();
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_data_we", 32'(data_we), 32'd0);
    chk("rst_data_addr", 32'(data_addr), 32'd0);
    chk("rst_rj_addr", 32'(rj_addr), 32'd0);
    chk("rst_coeff_addr", 32'(coeff_addr), 32'd0);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_sleep", 32'(sleep_flag), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // init sweep
    uni_reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i == 10) word_valid = 1'b1;
      step();
      word_valid = 1'b0;
      chk("init_we_clr", 32'({data_we, data_clear}), 32'd3);
      chk("init_addr", 32'(data_addr), 32'(i));
    end
    step();
    chk("init_done_state", 32'(state_dbg), 32'd1);
    chk("init_done_we", 32'(data_we), 32'd0);
    chk("init_done_addr", 32'(data_addr), 32'd0);
    chk("init_no_rj", 32'(rj_we), 32'd0);

    // rj and coeff loads
    for (int k = 0; k < 16; k++) begin
      word(1'b0);
      chk("rj_we", 32'(rj_we), 32'd1);
      chk("rj_addr", 32'(rj_addr), 32'(k));
      step();
      chk("rj_gap", 32'(rj_we), 32'd0);
    end
    chk("rj_done_state", 32'(state_dbg), 32'd2);
    for (int k = 0; k < 512; k++) begin
      word(1'b0);
      chk("coeff_we", 32'({coeff_we, rj_we, data_we}), 32'd4);
      chk("coeff_addr", 32'(coeff_addr), 32'(k));
      if (k == 511) chk("coeff_done_state", 32'(state_dbg), 32'd3);
      step();
    end

    // work flow, finishes 20 cycles after each start
    for (int k = 0; k < 300; k++) begin
      word(1'b0);
      chk("work_we", 32'({data_we, data_clear}), 32'd2);
      chk("work_addr", 32'(data_addr), 32'(k % 256));
      step();
      chk("work_start", 32'(alu_start), 32'd1);
      for (int j = 0; j < 19; j++) step();
      finish_both();
    end
    chk("work_overrun", 32'(overrun), 32'd0);

    // zero run into sleep
    for (int k = 0; k < 800; k++) begin
      word(1'b1);
      chk("zero_we", 32'(data_we), 32'd1);
      step();
      chk("zero_start", 32'(alu_start), 32'd1);
      finish_both();
      if (k == 798) chk("zero_not_yet", 32'(sleep_flag), 32'd0);
    end
    chk("sleep_flag", 32'(sleep_flag), 32'd1);
    chk("sleep_state", 32'(state_dbg), 32'd4);
    for (int k = 0; k < 5; k++) begin
      word(1'b1);
      chk("sleep_drop_we", 32'(data_we), 32'd0);
      step();
      chk("sleep_drop_start", 32'(alu_start), 32'd0);
    end
    chk("sleep_held", 32'(sleep_flag), 32'd1);

    // sleep exit, split finishes, overrun, same-cycle finishes
    for (int r = 0; r < 11; r++) begin
      word_valid   = tbl[r].wv;
      all_zero     = tbl[r].az;
      flush        = tbl[r].fl;
      alu_finish_L = tbl[r].fin_l;
      alu_finish_R = tbl[r].fin_r;
      step();
      chk("tbl_we", 32'(data_we), 32'(tbl[r].we));
      chk("tbl_clr", 32'(data_clear), 32'(tbl[r].clr));
      chk("tbl_addr", 32'(data_addr), 32'(tbl[r].addr));
      chk("tbl_start", 32'(alu_start), 32'(tbl[r].st));
      chk("tbl_sleep", 32'(sleep_flag), 32'(tbl[r].slp));
      chk("tbl_overrun", 32'(overrun), 32'(tbl[r].ovr));
      chk("tbl_state", 32'(state_dbg), 32'(tbl[r].sd));
    end
    word_valid   = 1'b0;
    flush        = 1'b0;
    alu_finish_L = 1'b0;
    alu_finish_R = 1'b0;

    // flush pulse while busy
    word(1'b0);
    chk("fl_word_addr", 32'(data_addr), 32'd79);
    step();
    chk("fl_word_start", 32'(alu_start), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_wait0", 32'(state_dbg), 32'd3);
    step();
    chk("fl_wait1", 32'(state_dbg), 32'd3);
    alu_finish_L = 1'b1;
    step();
    alu_finish_L = 1'b0;
    chk("fl_wait_l", 32'(state_dbg), 32'd3);
    alu_finish_R = 1'b1;
    step();
    alu_finish_R = 1'b0;
    chk("fl_wait_r", 32'(state_dbg), 32'd3);
    step();
    chk("fl_clear_state", 32'(state_dbg), 32'd5);
    chk("fl_clear_addr", 32'(data_addr), 32'd0);
    for (int i = 0; i < 256; i++) begin
      if (i == 100) word_valid = 1'b1;
      step();
      word_valid = 1'b0;
      chk("clr_we_clr", 32'({data_we, data_clear}), 32'd3);
      chk("clr_addr", 32'(data_addr), 32'(i));
      chk("clr_no_load", 32'({rj_we, coeff_we, alu_start}), 32'd0);
    end
    step();
    chk("clr_done_state", 32'(state_dbg), 32'd3);
    chk("clr_done_addr", 32'(data_addr), 32'd0);
    chk("clr_done_we", 32'(data_we), 32'd0);
    word(1'b0);
    chk("post_clr_write", 32'({data_we, data_clear}), 32'd2);
    chk("post_clr_addr", 32'(data_addr), 32'd0);
    step();
    chk("post_clr_start", 32'(alu_start), 32'd1);
    finish_both();

    // reset in the middle of the coefficient load
    uni_reset = 1'b1;
    step();
    uni_reset = 1'b0;
    chk("rst2_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 257; i++) step();
    chk("rst2_loadrj", 32'(state_dbg), 32'd1);
    for (int k = 0; k < 16; k++) begin
      word(1'b0);
      step();
    end
    flush = 1'b1;
    for (int k = 0; k < 10; k++) begin
      word(1'b0);
      step();
    end
    flush = 1'b0;
    chk("coeff_flush_ign", 32'(state_dbg), 32'd2);
    chk("coeff_part_addr", 32'(coeff_addr), 32'd10);
    uni_reset = 1'b1;
    step();
    chk("rst3_state", 32'(state_dbg), 32'd0);
    chk("rst3_coeff_addr", 32'(coeff_addr), 32'd0);
    chk("rst3_rj_addr", 32'(rj_addr), 32'd0);
    uni_reset = 1'b0;
    step();
    chk("rst3_init_we", 32'({data_we, data_clear}), 32'd3);
    chk("rst3_init_addr", 32'(data_addr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
